// File: rtl/alu_share_ctrl.sv
// Arbiter and sequencer that shares one multi-cycle ALU between two requesters.
// It holds the operands for a settle window, captures the result and flags, and owns the architectural flag register.
module alu_share_ctrl #(
    parameter int WIDTH  = 64,
    parameter int SETTLE = 2     // cycles operands are held on the ALU before capture, 1..15
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req0_setflags,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    input  logic             req1_setflags,

    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,

    output logic [3:0]       flags_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] count;
    logic       owner;
    logic       owner_setflags;
    logic       last_grant;
    logic       grant_any;
    logic       grant_sel;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_sel = 1'b0;
        if (req0_valid && req1_valid)
            grant_sel = ~last_grant;
        else
            grant_sel = req1_valid;
    end

    // Ready is gated by reset so the async clear also silences the handshake.
    assign req0_ready = (state == S_IDLE) & ~reset & req0_valid & ~grant_sel;
    assign req1_ready = (state == S_IDLE) & ~reset & req1_valid &  grant_sel;

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            count          <= '0;
            owner          <= 1'b0;
            owner_setflags <= 1'b0;
            last_grant     <= 1'b1;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= '0;
            rsp0_valid     <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp_result     <= '0;
            rsp_flags      <= '0;
            flags_q        <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        owner          <= grant_sel;
                        last_grant     <= grant_sel;
                        alu_a          <= grant_sel ? req1_a : req0_a;
                        alu_b          <= grant_sel ? req1_b : req0_b;
                        alu_op         <= grant_sel ? req1_op : req0_op;
                        owner_setflags <= grant_sel ? req1_setflags : req0_setflags;
                        count          <= SETTLE_LOAD;
                        state          <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (count == 4'd0) begin
                        rsp_result <= alu_result;
                        rsp_flags  <= alu_flags;
                        if (owner_setflags)
                            flags_q <= alu_flags;
                        state <= S_DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_DONE: begin
                    // The response pulse is registered on the way out of DONE.
                    rsp0_valid <= ~owner;
                    rsp1_valid <=  owner;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: timeline reference model, directed cases, random traffic.
// A second instance with SETTLE=1 checks the short-window latency and throughput.
module tb_alu_share_ctrl;

    localparam int W  = 64;
    localparam int ST = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         r0_valid, r0_ready, r0_sf, r1_valid, r1_ready, r1_sf;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
    logic [2:0]   r0_op, r1_op;
    logic         rsp0_valid, rsp1_valid;
    logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
    logic [3:0]   rsp_flags, alu_flags, flags_q;
    logic [2:0]   alu_op;

    logic         s_r0_valid, s_r0_ready, s_r0_sf, s_r1_valid, s_r1_ready, s_r1_sf;
    logic [W-1:0] s_r0_a, s_r0_b, s_r1_a, s_r1_b;
    logic [2:0]   s_r0_op, s_r1_op;
    logic         s_rsp0_valid, s_rsp1_valid;
    logic [W-1:0] s_rsp_result, s_alu_a, s_alu_b, s_alu_result;
    logic [3:0]   s_rsp_flags, s_alu_flags, s_flags_q;
    logic [2:0]   s_alu_op;

    int checks = 0;
    int errors = 0;

    alu_share_ctrl #(.WIDTH(W), .SETTLE(ST)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_a(r0_a), .req0_b(r0_b),
        .req0_op(r0_op), .req0_setflags(r0_sf),
        .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_a(r1_a), .req1_b(r1_b),
        .req1_op(r1_op), .req1_setflags(r1_sf),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .flags_q(flags_q)
    );

    alu_share_ctrl #(.WIDTH(W), .SETTLE(1)) u_dut_s1 (
        .clk(clk), .reset(reset),
        .req0_valid(s_r0_valid), .req0_ready(s_r0_ready), .req0_a(s_r0_a), .req0_b(s_r0_b),
        .req0_op(s_r0_op), .req0_setflags(s_r0_sf),
        .req1_valid(s_r1_valid), .req1_ready(s_r1_ready), .req1_a(s_r1_a), .req1_b(s_r1_b),
        .req1_op(s_r1_op), .req1_setflags(s_r1_sf),
        .rsp0_valid(s_rsp0_valid), .rsp1_valid(s_rsp1_valid),
        .rsp_result(s_rsp_result), .rsp_flags(s_rsp_flags),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op),
        .alu_result(s_alu_result), .alu_flags(s_alu_flags),
        .flags_q(s_flags_q)
    );

    assign s_alu_result = s_alu_a + s_alu_b;
    assign s_alu_flags  = 4'b0000;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass a. Returns {result, N, Z, V, C}.
    function automatic logic [W+3:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         v, c;
        s = '0; r = '0; v = 1'b0; c = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = s[W];
                        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: r = a;
        endcase
        return {r, r[W-1], (r == '0), v, c};
    endfunction

    // Gate-level ALU stand-in: output is wrong until the operands have been stable long enough.
    int            stable = 0;
    logic [2*W+2:0] prev_alu;
    logic [W+3:0]  alu_model;
    always @(negedge clk) begin
        if ({alu_a, alu_b, alu_op} !== prev_alu) stable = 0;
        else stable++;
        prev_alu = {alu_a, alu_b, alu_op};
    end
    always_comb begin
        alu_model = alu_f(alu_a, alu_b, alu_op);
        if (stable >= ST - 1) {alu_result, alu_flags} = alu_model;
        else                  {alu_result, alu_flags} = ~alu_model;
    end

    // Timeline reference model: one op in flight, response SETTLE+2 sampled cycles after the ready cycle.
    bit           model_on = 0;
    int           cyc = 0, busy_until = 0, last_g = 1, w = 0;
    bit           idle, e0, e1, resp_now;
    logic [3:0]   m_flags;
    logic [W-1:0] h_a, h_b;
    logic [2:0]   h_op;
    bit           pend = 0, pend_sf;
    int           pend_cyc, pend_own;
    logic [W-1:0] pend_res;
    logic [3:0]   pend_fl;
    int           rsp_log[$];
    int           grant_log[$];

    always @(negedge clk) if (model_on) begin
        if (reset) begin
            busy_until = 0; last_g = 1; m_flags = '0; pend = 0;
            h_a = '0; h_b = '0; h_op = '0;
            check("reset_ctrl", {r0_ready, r1_ready, rsp0_valid, rsp1_valid, rsp_flags, flags_q, alu_op}, '0);
            check("reset_rsp_result", rsp_result, '0);
            check("reset_alu_a", alu_a, '0);
            check("reset_alu_b", alu_b, '0);
        end else begin
            cyc++;
            if (rsp0_valid) rsp_log.push_back(0);
            if (rsp1_valid) rsp_log.push_back(1);
            resp_now = pend && (pend_cyc == cyc);
            check("rsp0_valid", rsp0_valid, resp_now && pend_own == 0);
            check("rsp1_valid", rsp1_valid, resp_now && pend_own == 1);
            if (resp_now) begin
                check("rsp_result", rsp_result, pend_res);
                check("rsp_flags", rsp_flags, pend_fl);
                pend = 0;
            end
            if (pend && pend_sf && cyc == pend_cyc - 1) m_flags = pend_fl;
            check("flags_q", flags_q, m_flags);
            check("alu_a", alu_a, h_a);
            check("alu_b", alu_b, h_b);
            check("alu_op", alu_op, h_op);

            idle = (cyc >= busy_until);
            if (r0_valid && r1_valid) w = (last_g == 1) ? 0 : 1;
            else                      w = r1_valid ? 1 : 0;
            e0 = idle && r0_valid && (w == 0);
            e1 = idle && r1_valid && (w == 1);
            check("req0_ready", r0_ready, e0);
            check("req1_ready", r1_ready, e1);
            if (r0_ready && r0_valid) grant_log.push_back(0);
            if (r1_ready && r1_valid) grant_log.push_back(1);
            if (e0 || e1) begin
                h_a  = (w == 1) ? r1_a  : r0_a;
                h_b  = (w == 1) ? r1_b  : r0_b;
                h_op = (w == 1) ? r1_op : r0_op;
                pend_sf  = (w == 1) ? r1_sf : r0_sf;
                {pend_res, pend_fl} = alu_f(h_a, h_b, h_op);
                last_g     = w;
                busy_until = cyc + ST + 2;
                pend       = 1;
                pend_cyc   = cyc + ST + 2;
                pend_own   = w;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, input logic sf);
        if (r == 0) begin r0_valid = v; r0_a = a; r0_b = b; r0_op = op; r0_sf = sf; end
        else        begin r1_valid = v; r1_a = a; r1_b = b; r1_op = op; r1_sf = sf; end
    endtask

    // Issues one op and returns the number of edges from the accept edge to the response.
    task automatic do_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic sf, output int lat);
        int k;
        set_req(r, 1'b1, a, b, op, sf);
        k = 0;
        @(negedge clk);
        while (!(r == 0 ? r0_ready : r1_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("op_accept_seen", (r == 0 ? r0_ready : r1_ready), 1);
        tick();
        if (r == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!(r == 0 ? rsp0_valid : rsp1_valid) && lat < 20);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return W'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k, n0, g0;
        logic [W-1:0] hold_a;
        int acc[$];
        int rsp[$];

        reset = 1'b1;
        set_req(0, 1'b0, '0, '0, 3'd0, 1'b0);
        set_req(1, 1'b0, '0, '0, 3'd0, 1'b0);
        s_r0_valid = 0; s_r0_a = '0; s_r0_b = '0; s_r0_op = '0; s_r0_sf = 0;
        s_r1_valid = 0; s_r1_a = '0; s_r1_b = '0; s_r1_op = '0; s_r1_sf = 0;
        tick();
        model_on = 1;
        tick();
        reset = 1'b0;

        // Single OR op from requester 0.
        tick();
        do_op(0, 64'd5, 64'd3, 3'd3, 1'b1, lat);
        check("t1_latency", lat, 3);
        check("t1_result", rsp_result, 64'd7);
        check("t1_rsp_flags", rsp_flags, 4'b0000);
        check("t1_flags_q", flags_q, 4'b0000);

        // Zero result sets Z; a later non-setflags op leaves flags_q alone.
        tick();
        do_op(1, 64'd0, 64'd0, 3'd3, 1'b1, lat);
        check("t2_result", rsp_result, 64'd0);
        check("t2_flags_q", flags_q, 4'b0100);
        tick();
        do_op(1, 64'h8000_0000_0000_0000, 64'd0, 3'd3, 1'b0, lat);
        check("t2_neg_result", rsp_result, 64'h8000_0000_0000_0000);
        check("t2_neg_rsp_flags", rsp_flags, 4'b1000);
        check("t2_neg_flags_q", flags_q, 4'b0100);

        // Contention: both held valid, grants must alternate starting with requester 0.
        tick();
        n0 = rsp_log.size();
        g0 = grant_log.size();
        set_req(0, 1'b1, 64'd10, 64'd1, 3'd0, 1'b0);
        set_req(1, 1'b1, 64'd20, 64'd2, 3'd1, 1'b0);
        k = 0;
        while (rsp_log.size() < n0 + 4 && k < 100) begin
            @(negedge clk);
            k++;
        end
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        check("t3_rsp_count", rsp_log.size() >= n0 + 4, 1);
        if (rsp_log.size() >= n0 + 4 && grant_log.size() >= g0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t3_grant_order", grant_log[g0 + i], i % 2);
                check("t3_rsp_owner", rsp_log[n0 + i], i % 2);
            end
        end
        repeat (ST + 4) tick();

        // Hold check: requester 0 payload changes while waiting; the accept-edge value is used.
        set_req(0, 1'b1, 64'd100, 64'd7, 3'd0, 1'b0);
        set_req(1, 1'b1, 64'd9, 64'd1, 3'd0, 1'b1);
        @(negedge clk);
        check("t4_req1_first", r1_ready, 1);
        tick();
        r1_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            r0_a = 64'd200 + W'(k);
            @(negedge clk);
            if (r0_ready) break;
            tick();
            k++;
        end
        hold_a = r0_a;
        check("t4_req0_ready", r0_ready, 1);
        tick();
        r0_valid = 1'b0;
        r0_a = 64'hDEAD_BEEF;
        repeat (ST) begin
            @(negedge clk);
            check("t4_alu_a_hold", alu_a, hold_a);
        end
        repeat (ST + 2) tick();

        // Reset one cycle after accepting a setflags op aborts it.
        set_req(0, 1'b1, 64'd0, 64'd0, 3'd3, 1'b1);
        @(negedge clk);
        check("t5_accept", r0_ready, 1);
        tick();
        r0_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        k = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) k++;
        end
        check("t5_no_rsp", k, 0);
        check("t5_flags_q", flags_q, 4'b0000);
        tick();
        do_op(1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b1, lat);
        check("t5_after_latency", lat, 3);
        check("t5_after_result", rsp_result, 64'd0);
        check("t5_after_flags_q", flags_q, 4'b0101);

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            tick();
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            set_req(0, $urandom_range(0, 2) != 0, rnd_val(), rnd_val(), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)));
            set_req(1, $urandom_range(0, 2) != 0, rnd_val(), rnd_val(), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)));
        end
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        repeat (ST + 4) tick();

        // SETTLE=1 instance: 2-edge latency, one accept every 3 cycles under continuous demand.
        s_r0_valid = 1'b1; s_r0_a = 64'd10; s_r0_b = 64'd20; s_r0_op = 3'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (s_r0_ready) acc.push_back(i);
            if (s_rsp0_valid) begin
                rsp.push_back(i);
                check("s1_result", s_rsp_result, 64'd30);
            end
            check("s1_no_rsp1", s_rsp1_valid, 0);
            tick();
        end
        s_r0_valid = 1'b0;
        check("s1_accepts", acc.size() >= 3, 1);
        check("s1_rsps", rsp.size() >= 1, 1);
        if (acc.size() >= 3) begin
            check("s1_gap0", acc[1] - acc[0], 3);
            check("s1_gap1", acc[2] - acc[1], 3);
        end
        if (acc.size() >= 1 && rsp.size() >= 1)
            check("s1_latency", rsp[0] - acc[0] - 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
